// File: rtl/cu_edge_data_write_arbiter.sv
// cu_edge_data_write_arbiter
// Round-robin arbiter that shares one edge-data write path among NUM_REQ
// sum-kernel requesters. A registered one-hot grant lets a kernel pop its
// write FIFO. The popped beat returns some cycles later and is merged onto
// one registered output toward the CU write-command buffer. An in-flight
// credit counter covers the lag between grant and returned data, so new
// grants stop before the downstream buffer can be overrun.
//
// Optional build macro: CU_WRITE_ARB_STATS_EN adds per-requester grant
// counters (grant_count_out) and a stall-cycle counter (stall_cycles_out).
// Both are 32 bits wide and saturate at all-ones.
//
// State table:
//   DISABLED | no grants, returned beats dropped; leaves when registered enable is 1
//   ARB      | one grant may be issued per cycle
//   STALL    | downstream almost full or credits exhausted; no grants
//   DRAIN    | enable dropped; no grants, beats still merged until inflight is 0

module cu_edge_data_write_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 64,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                      clock,
    input  logic                      rstn,
    input  logic                      enabled_in,
    input  logic [NUM_REQ-1:0]        req_in,
    output logic [NUM_REQ-1:0]        grant_out,
    input  logic [NUM_REQ-1:0]        data_valid_in,
    input  logic [NUM_REQ*DATA_W-1:0] data_payload_in,
    input  logic                      downstream_alfull,
    output logic                      data_valid_out,
    output logic [DATA_W-1:0]         data_payload_out,
    output logic [3:0]                inflight_out,
    output logic                      error_out
`ifdef CU_WRITE_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]     grant_count_out,
    output logic [31:0]               stall_cycles_out
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_DISABLED = 2'd0,
        S_ARB      = 2'd1,
        S_STALL    = 2'd2,
        S_DRAIN    = 2'd3
    } state_t;

    state_t              state_q;
    logic                en_q;
    logic [PTR_W-1:0]    ptr_q;
    logic [NUM_REQ-1:0]  grant_q;
    logic                data_valid_q;
    logic [DATA_W-1:0]   payload_q;
    logic [3:0]          inflight_q;
    logic                error_q;

    logic                beat_any;
    logic                beat_multi;
    logic                beat_underflow;
    logic [PTR_W-1:0]    beat_idx;
    logic [DATA_W-1:0]   beat_payload;
    logic [3:0]          inflight_d;
    logic                credit_ok;
    logic                req_found;
    logic [PTR_W-1:0]    win_idx;
    logic [PTR_W-1:0]    ptr_d;
    logic                may_grant;
    logic [NUM_REQ-1:0]  grant_d;
    int                  scan_idx;

    // Decode the returned beats: accept only outside DISABLED, forward the lowest index.
    always_comb begin
        beat_any       = (state_q != S_DISABLED) && (data_valid_in != '0);
        beat_multi     = beat_any &&
                         ((data_valid_in & (data_valid_in - NUM_REQ'(1))) != '0);
        beat_idx       = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (data_valid_in[i]) begin
                beat_idx = PTR_W'(i);
            end
        end
        beat_payload   = data_payload_in[int'(beat_idx)*DATA_W +: DATA_W];
        beat_underflow = beat_any && (inflight_q == 4'd0);
    end

    // Credit arithmetic: the visible grant adds one, an accepted beat removes one.
    // The gate uses the next counter value because the grant issued at this
    // edge is only counted one cycle later.
    always_comb begin
        inflight_d = inflight_q + 4'(grant_q != '0) - 4'(beat_any && !beat_underflow);
        credit_ok  = inflight_d < 4'(MAX_INFLIGHT);
    end

    // Round-robin search starting at the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        req_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = int'(ptr_q) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!req_found && req_in[scan_idx]) begin
                req_found = 1'b1;
                win_idx   = PTR_W'(scan_idx);
            end
        end
        ptr_d = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
    end

    // A grant leaves only when granting is allowed this cycle; STALL may hand
    // over directly so the grant appears one cycle after the blocking cause clears.
    always_comb begin
        may_grant = ((state_q == S_ARB) || (state_q == S_STALL)) && en_q &&
                    !downstream_alfull && credit_ok;
        grant_d   = (may_grant && req_found) ? (NUM_REQ'(1) << win_idx) : '0;
    end

    // FSM with registered grant, merge output, credit counter and sticky error.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_DISABLED;
            en_q         <= 1'b0;
            ptr_q        <= '0;
            grant_q      <= '0;
            data_valid_q <= 1'b0;
            payload_q    <= '0;
            inflight_q   <= 4'd0;
            error_q      <= 1'b0;
        end else begin
            en_q         <= enabled_in;
            grant_q      <= grant_d;
            if (grant_d != '0) begin
                ptr_q <= ptr_d;
            end
            inflight_q   <= inflight_d;
            error_q      <= error_q | beat_multi | beat_underflow;
            data_valid_q <= beat_any;
            if (beat_any) begin
                payload_q <= beat_payload;
            end
            case (state_q)
                S_DISABLED: begin
                    if (en_q) begin
                        state_q <= S_ARB;
                    end
                end
                S_ARB, S_STALL: begin
                    if (!en_q) begin
                        state_q <= S_DRAIN;
                    end else if (downstream_alfull || !credit_ok) begin
                        state_q <= S_STALL;
                    end else begin
                        state_q <= S_ARB;
                    end
                end
                S_DRAIN: begin
                    if (inflight_d == 4'd0) begin
                        state_q <= S_DISABLED;
                    end
                end
                default: state_q <= S_DISABLED;
            endcase
        end
    end

    assign grant_out        = grant_q;
    assign data_valid_out   = data_valid_q;
    assign data_payload_out = payload_q;
    assign inflight_out     = inflight_q;
    assign error_out        = error_q;

`ifdef CU_WRITE_ARB_STATS_EN
    logic [31:0] grant_cnt_q [NUM_REQ];
    logic [31:0] stall_cnt_q;

    // Saturating usage counters: grants per requester and cycles spent in STALL.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt_q[i] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_q[i] && (grant_cnt_q[i] != '1)) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
                end
            end
            if ((state_q == S_STALL) && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
        assign grant_count_out[g*32 +: 32] = grant_cnt_q[g];
    end
    assign stall_cycles_out = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cu_edge_data_write_arbiter.sv
// Bench for cu_edge_data_write_arbiter: two instances (MAX_INFLIGHT 4 and 2)
// checked every cycle against a behavioural model, plus literal expectations.
module tb_cu_edge_data_write_arbiter;
    localparam int N = 4;
    localparam int W = 64;
    localparam int M_OFF = 0, M_RUN = 1, M_HOLD = 2, M_DRAIN = 3;

    logic clock;
    logic rstn;
    logic           en_s    [2];
    logic [N-1:0]   req_s   [2];
    logic [N-1:0]   dvin_s  [2];
    logic [N*W-1:0] pay_s   [2];
    logic           alf_s   [2];
    logic [N-1:0]   grant_s [2];
    logic           dvo_s   [2];
    logic [W-1:0]   payo_s  [2];
    logic [3:0]     infl_s  [2];
    logic           err_s   [2];
`ifdef CU_WRITE_ARB_STATS_EN
    logic [N*32-1:0] gcnt_s [2];
    logic [31:0]     scnt_s [2];
`endif

    int max_of [2] = '{4, 2};

    // scenario controls
    logic         sc_rstn;
    logic         sc_en   [2];
    logic [N-1:0] sc_req  [2];
    logic         sc_alf  [2];
    logic [N-1:0] man_dv  [2];
    bit           autoret [2];
    // kernel emulator: beat returns 3 cycles after its grant
    bit           p_v [2][4];
    int           p_i [2][4];

    // behavioural model
    int           m_mode [2];
    int           m_ptr  [2];
    int           m_iss  [2];
    int           m_ret  [2];
    logic [N-1:0] m_grant[2];
    logic         m_dv   [2];
    logic [W-1:0] m_pay  [2];
    logic         m_err  [2];
    logic         m_en   [2];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int t5c;

    cu_edge_data_write_arbiter #(.NUM_REQ(N), .DATA_W(W), .MAX_INFLIGHT(4)) dut_a (
        .clock(clock), .rstn(rstn), .enabled_in(en_s[0]), .req_in(req_s[0]),
        .grant_out(grant_s[0]), .data_valid_in(dvin_s[0]), .data_payload_in(pay_s[0]),
        .downstream_alfull(alf_s[0]), .data_valid_out(dvo_s[0]),
        .data_payload_out(payo_s[0]), .inflight_out(infl_s[0]), .error_out(err_s[0])
`ifdef CU_WRITE_ARB_STATS_EN
        , .grant_count_out(gcnt_s[0]), .stall_cycles_out(scnt_s[0])
`endif
    );

    cu_edge_data_write_arbiter #(.NUM_REQ(N), .DATA_W(W), .MAX_INFLIGHT(2)) dut_b (
        .clock(clock), .rstn(rstn), .enabled_in(en_s[1]), .req_in(req_s[1]),
        .grant_out(grant_s[1]), .data_valid_in(dvin_s[1]), .data_payload_in(pay_s[1]),
        .downstream_alfull(alf_s[1]), .data_valid_out(dvo_s[1]),
        .data_payload_out(payo_s[1]), .inflight_out(infl_s[1]), .error_out(err_s[1])
`ifdef CU_WRITE_ARB_STATS_EN
        , .grant_count_out(gcnt_s[1]), .stall_cycles_out(scnt_s[1])
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [W-1:0] slice_val(input int n, input int i, input int c);
        return {8'(n + 1), 8'(i), 16'(c), 32'hBEEF_0000 | 32'(i)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset(input int n);
        m_mode[n] = M_OFF; m_ptr[n] = 0; m_iss[n] = 0; m_ret[n] = 0;
        m_grant[n] = '0; m_dv[n] = 1'b0; m_pay[n] = '0; m_err[n] = 1'b0; m_en[n] = 1'b0;
        for (int k = 0; k < 4; k++) begin p_v[n][k] = 1'b0; p_i[n][k] = 0; end
    endtask

    // One clock of the rules: credits from visible grants and accepted beats,
    // merge of the lowest returned slice, round-robin grant, mode changes.
    task automatic model_step(input int n);
        int outstanding, nxt, low, won, cand;
        bit acc;
        outstanding = m_iss[n] - m_ret[n];
        acc = (m_mode[n] != M_OFF) && (dvin_s[n] != '0);
        if (acc) begin
            if (outstanding == 0) m_err[n] = 1'b1;
            else m_ret[n]++;
            if ($countones(dvin_s[n]) > 1) m_err[n] = 1'b1;
            low = 0;
            for (int i = N - 1; i >= 0; i--) if (dvin_s[n][i]) low = i;
            m_pay[n] = pay_s[n][low*W +: W];
        end
        m_dv[n] = acc;
        if (m_grant[n] != '0) m_iss[n]++;
        nxt = m_iss[n] - m_ret[n];
        m_grant[n] = '0;
        if ((m_mode[n] == M_RUN || m_mode[n] == M_HOLD) && m_en[n] && !alf_s[n] &&
            nxt < max_of[n]) begin
            won = -1;
            for (int k = 0; k < N; k++) begin
                cand = (m_ptr[n] + k) % N;
                if (won < 0 && req_s[n][cand]) won = cand;
            end
            if (won >= 0) begin
                m_grant[n] = N'(1) << won;
                m_ptr[n] = (won + 1) % N;
            end
        end
        case (m_mode[n])
            M_OFF:   if (m_en[n]) m_mode[n] = M_RUN;
            M_DRAIN: if (nxt == 0) m_mode[n] = M_OFF;
            default: begin
                if (!m_en[n]) m_mode[n] = M_DRAIN;
                else if (alf_s[n] || nxt >= max_of[n]) m_mode[n] = M_HOLD;
                else m_mode[n] = M_RUN;
            end
        endcase
        m_en[n] = en_s[n];
    endtask

    // Per cycle: compare at the falling edge, then drive inputs and advance the model.
    task automatic step();
        logic [N-1:0] ret;
        @(negedge clock);
        for (int n = 0; n < 2; n++) begin
            chk($sformatf("grant%0d", n), 64'(grant_s[n]), 64'(m_grant[n]));
            chk($sformatf("dvalid%0d", n), 64'(dvo_s[n]), 64'(m_dv[n]));
            chk($sformatf("payload%0d", n), payo_s[n], m_pay[n]);
            chk($sformatf("inflight%0d", n), 64'(infl_s[n]), 64'(m_iss[n] - m_ret[n]));
            chk($sformatf("error%0d", n), 64'(err_s[n]), 64'(m_err[n]));
        end
        rstn = sc_rstn;
        for (int n = 0; n < 2; n++) begin
            for (int k = 0; k < 3; k++) begin p_v[n][k] = p_v[n][k+1]; p_i[n][k] = p_i[n][k+1]; end
            ret = '0;
            if (p_v[n][0]) ret[p_i[n][0]] = 1'b1;
            p_v[n][3] = 1'b0;
            if (autoret[n] && m_grant[n] != '0) begin
                p_v[n][3] = 1'b1;
                for (int i = 0; i < N; i++) if (m_grant[n][i]) p_i[n][3] = i;
            end
            dvin_s[n] = ret | man_dv[n];
            man_dv[n] = '0;
            for (int i = 0; i < N; i++) pay_s[n][i*W +: W] = slice_val(n, i, cyc);
            en_s[n]  = sc_en[n];
            req_s[n] = sc_req[n];
            alf_s[n] = sc_alf[n];
            if (!sc_rstn) model_reset(n);
            else model_step(n);
        end
        cyc++;
    endtask

    initial begin
        rstn = 1'b0;
        sc_rstn = 1'b0;
        for (int n = 0; n < 2; n++) begin
            sc_en[n] = 1'b0; sc_req[n] = '0; sc_alf[n] = 1'b0; man_dv[n] = '0; autoret[n] = 1'b0;
            en_s[n] = 1'b0; req_s[n] = '0; dvin_s[n] = '0; pay_s[n] = '0; alf_s[n] = 1'b0;
            model_reset(n);
        end
        repeat (3) step();
        chk("rst_grant", 64'(grant_s[0]), 64'h0);
        chk("rst_inflight", 64'(infl_s[0]), 64'h0);
        chk("rst_error", 64'(err_s[0]), 64'h0);
        sc_rstn = 1'b1;
        step(); step();

        // all four requesting, beats back after 3 cycles
        sc_en[0] = 1'b1; sc_req[0] = 4'b1111; autoret[0] = 1'b1;
        repeat (4) step();
        chk("rr_g0", 64'(grant_s[0]), 64'b0001);
        step(); chk("rr_g1", 64'(grant_s[0]), 64'b0010);
        step(); chk("rr_g2", 64'(grant_s[0]), 64'b0100);
        step(); chk("rr_g3", 64'(grant_s[0]), 64'b1000);
        step(); chk("rr_g4", 64'(grant_s[0]), 64'b0001);
        repeat (6) step();
        chk("rr_inflight3", 64'(infl_s[0]), 64'd3);
        chk("rr_dvalid", 64'(dvo_s[0]), 64'd1);
        chk("rr_error", 64'(err_s[0]), 64'd0);

        // downstream almost full
        sc_alf[0] = 1'b1;
        step(); chk("alf_last_grant", 64'(grant_s[0]), 64'b1000);
        step(); chk("alf_grant_off", 64'(grant_s[0]), 64'h0);
        repeat (6) step();
        chk("alf_still_off", 64'(grant_s[0]), 64'h0);
        chk("alf_drained", 64'(infl_s[0]), 64'd0);
        sc_alf[0] = 1'b0;
        step(); step();
        chk("alf_resume", 64'(grant_s[0]), 64'b0001);

        // enable drop with beats outstanding
        repeat (5) step();
        chk("drain_start_inflight", 64'(infl_s[0]), 64'd3);
        sc_en[0] = 1'b0; sc_req[0] = '0;
        repeat (9) step();
        chk("drain_grant", 64'(grant_s[0]), 64'h0);
        chk("drain_inflight", 64'(infl_s[0]), 64'd0);
        man_dv[0] = 4'b0001;
        step(); step();
        chk("disabled_drop_infl", 64'(infl_s[0]), 64'd0);
        chk("disabled_drop_dv", 64'(dvo_s[0]), 64'd0);
        chk("disabled_drop_err", 64'(err_s[0]), 64'd0);

        // two beats returned in one cycle
        sc_en[0] = 1'b1; autoret[0] = 1'b0;
        step(); step();
        sc_req[0] = 4'b0001;
        step();
        sc_req[0] = '0;
        step(); chk("single_grant", 64'(grant_s[0]), 64'b0001);
        step(); chk("single_infl", 64'(infl_s[0]), 64'd1);
        man_dv[0] = 4'b0110; t5c = cyc;
        step(); step();
        chk("multi_err", 64'(err_s[0]), 64'd1);
        chk("multi_dv", 64'(dvo_s[0]), 64'd1);
        chk("multi_payload", payo_s[0], slice_val(0, 1, t5c));
        repeat (3) step();
        chk("multi_sticky", 64'(err_s[0]), 64'd1);

        // reset mid-stream
        sc_req[0] = 4'b0011;
        step(); step();
        sc_req[0] = '0;
        step(); step();
        chk("pre_rst_infl", 64'(infl_s[0]), 64'd2);
        rstn = 1'b0; sc_rstn = 1'b0;
        #1;
        chk("mid_rst_grant", 64'(grant_s[0]), 64'h0);
        chk("mid_rst_dv", 64'(dvo_s[0]), 64'h0);
        chk("mid_rst_pay", payo_s[0], 64'h0);
        chk("mid_rst_infl", 64'(infl_s[0]), 64'h0);
        chk("mid_rst_err", 64'(err_s[0]), 64'h0);
        for (int n = 0; n < 2; n++) model_reset(n);
        step(); step();
        sc_rstn = 1'b1; man_dv[0] = 4'b0001;
        step(); step();
        chk("post_rst_infl", 64'(infl_s[0]), 64'd0);
        chk("post_rst_dv", 64'(dvo_s[0]), 64'd0);
        chk("post_rst_err", 64'(err_s[0]), 64'd0);

        // MAX_INFLIGHT=2 instance, no returns
        sc_en[1] = 1'b1; sc_req[1] = 4'b0101;
        repeat (4) step();
        chk("cr_g0", 64'(grant_s[1]), 64'b0001);
        step(); chk("cr_g2", 64'(grant_s[1]), 64'b0100);
        step(); chk("cr_stall", 64'(grant_s[1]), 64'h0);
        repeat (3) step();
        chk("cr_stall_hold", 64'(grant_s[1]), 64'h0);
        chk("cr_infl2", 64'(infl_s[1]), 64'd2);
        man_dv[1] = 4'b0001;
        step(); step();
        chk("cr_resume_g0", 64'(grant_s[1]), 64'b0001);
        chk("cr_resume_infl", 64'(infl_s[1]), 64'd1);

        // returning more beats than were granted
        sc_req[1] = '0;
        man_dv[1] = 4'b0001; step();
        man_dv[1] = 4'b0001; step();
        step();
        chk("uf_infl0", 64'(infl_s[1]), 64'd0);
        chk("uf_no_err", 64'(err_s[1]), 64'd0);
        man_dv[1] = 4'b0001; step();
        step();
        chk("uf_err", 64'(err_s[1]), 64'd1);
        chk("uf_no_wrap", 64'(infl_s[1]), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cu_edge_data_write_arbiter.md
Name: cu_edge_data_write_arbiter

Overview:
- Round-robin arbiter that shares one edge-data write path among NUM_REQ sum-kernel requesters.
- Each kernel raises a write-bus request. The arbiter returns a one-hot registered grant, which the kernel uses to pop its write FIFO.
- The kernel's popped EdgeDataWrite beat returns a few cycles later. The arbiter merges the returned beats onto one registered output toward the CU write-command buffer.
- An in-flight credit counter keeps the downstream almost-full signal safe despite the grant-to-data lag.

Parameters:
- NUM_REQ, 4, number of requesting kernels (2..16).
- DATA_W, 64, width of one write-beat payload (flattened EdgeDataWrite payload).
- MAX_INFLIGHT, 4, maximum grants issued without their data having returned (1..15).

Ports:
- clock  in  1  clock
- rstn  in  1  asynchronous active-low reset
- enabled_in  in  1  block enable; registered internally
- req_in  in  NUM_REQ  per-kernel write-bus request
- grant_out  out  NUM_REQ  one-hot grant, registered
- data_valid_in  in  NUM_REQ  per-kernel returned-beat valid
- data_payload_in  in  NUM_REQ*DATA_W  per-kernel payloads; requester i occupies slice [i*DATA_W +: DATA_W]
- downstream_alfull  in  1  write-command buffer almost full
- data_valid_out  out  1  merged beat valid, registered
- data_payload_out  out  DATA_W  merged beat payload, registered
- inflight_out  out  4  outstanding grant count
- error_out  out  1  sticky protocol error

Behaviour:
- Reset values: grant_out=0, data_valid_out=0, data_payload_out=0, inflight_out=0, error_out=0, round-robin pointer=0, state=DISABLED, enable register=0.
- Reset asserted mid-operation: all state clears immediately. In-flight beats that arrive afterwards are dropped while the block is in DISABLED.
- FSM states:
  - DISABLED: grant_out=0; input beats ignored. Goes to ARB when the registered enable is 1.
  - ARB: one grant may be issued per cycle.
  - STALL: entered from ARB when downstream_alfull=1 or inflight==MAX_INFLIGHT. grant_out=0 while in STALL. Returns to ARB when downstream_alfull=0 and inflight<MAX_INFLIGHT.
  - DRAIN: entered from ARB or STALL when the enable drops. No new grants. Beats are still merged. Goes to DISABLED when inflight==0.
- Grant rule (ARB only):
  - Search for the first asserted req_in at index ptr, ptr+1, ... modulo NUM_REQ.
  - Drive the winner's grant bit for exactly one cycle; latency from req_in to grant_out is 1 cycle.
  - Pointer becomes winner+1, wrapping from NUM_REQ-1 to 0.
  - No request: grant_out=0 and the pointer holds.
  - A requester may win in consecutive cycles only if no other requester is asserting req_in.
- Credit counter:
  - +1 on each cycle in which grant_out is nonzero; -1 on each accepted returned beat.
  - Grant and return in the same cycle: counter unchanged.
  - Return while inflight==0: set error_out; the counter does not underflow.
- Merge:
  - Exactly one data_valid_in bit set: that slice is registered to data_payload_out and data_valid_out=1 on the next cycle.
  - Latency from data_valid_in to data_valid_out is 1 cycle.
  - No bit set: data_valid_out=0 and the payload holds its value.
  - More than one bit set: set error_out and forward the lowest index.
  - A beat arriving in DISABLED is dropped without affecting the counter.
- error_out clears only on reset.

Optional Feature:
- Macro: CU_WRITE_ARB_STATS_EN.
- Defined: the block adds a 32-bit grant counter per requester (grant_count_out, NUM_REQ*32, out) and a 32-bit stall-cycle counter (stall_cycles_out, 32, out).
  - A grant counter increments on each grant to its requester.
  - The stall counter increments each cycle spent in STALL.
  - Both reset to 0 and saturate at all-ones.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Setup: NUM_REQ=4, enable on, req_in=4'b1111 held, each beat returned 3 cycles after its grant.
  -> Grants go to 0,1,2,3,0,... one per cycle; inflight settles at 3; data_valid_out asserted every cycle once the pipe fills; error_out=0.
- Setup: MAX_INFLIGHT=2, no beats returned, req_in=4'b0101.
  -> Grants to 0 then 2, then STALL; grant_out=0 until a beat returns, then the next grant goes to 0.
- Setup: downstream_alfull=1 raised during continuous requests.
  -> grant_out=0 from the next cycle; granting resumes with the next pointer index one cycle after alfull falls.
- Setup: drop enabled_in with inflight=3.
  -> No further grants; the three returning beats appear on data_valid_out; state reaches DISABLED when inflight=0.
- Setup: data_valid_in=4'b0110 in one cycle.
  -> error_out=1 (sticky); data_payload_out equals slice 1.
- Setup: assert rstn=0 mid-stream with inflight=2.
  -> All outputs 0 immediately; after release, beats arriving before enable is re-registered are dropped and inflight stays 0.
